// File: rtl/dir_input_queue_pkg.sv
// Shared direction codes, key bit indices and helpers for the snake input stage.
package dir_input_queue_pkg;

  typedef logic [2:0] dir_t;

  localparam dir_t DIR_NONE  = 3'd0;
  localparam dir_t DIR_UP    = 3'd1;
  localparam dir_t DIR_DOWN  = 3'd2;
  localparam dir_t DIR_LEFT  = 3'd3;
  localparam dir_t DIR_RIGHT = 3'd4;

  localparam int unsigned KEY_RIGHT = 0;
  localparam int unsigned KEY_LEFT  = 1;
  localparam int unsigned KEY_DOWN  = 2;
  localparam int unsigned KEY_UP    = 3;

  function automatic dir_t opposite(input dir_t d);
    unique case (d)
      DIR_UP:    opposite = DIR_DOWN;
      DIR_DOWN:  opposite = DIR_UP;
      DIR_LEFT:  opposite = DIR_RIGHT;
      DIR_RIGHT: opposite = DIR_LEFT;
      default:   opposite = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dir_input_queue_if.sv
// Button/tick inputs and direction outputs of the snake input stage.
interface dir_input_queue_if;
  import dir_input_queue_pkg::*;

  logic [3:0] key_n;
  logic       tick;
  logic       lock;
  dir_t       dir_out;
  logic       started;
  logic [1:0] q_count;

  modport master (
    output key_n, tick, lock,
    input  dir_out, started, q_count
  );

  modport slave (
    input  key_n, tick, lock,
    output dir_out, started, q_count
  );

endinterface

// File: rtl/dir_input_queue_key_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one active-low button.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic stable_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differ, flip;

  assign differ = (sync2_q != stable_q);
  // Flip on the edge where the count would reach DEBOUNCE_CYCLES-1.
  assign flip   = differ && (cnt_q == LastCnt);

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (!differ || flip) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (flip) begin
      stable_d = sync2_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= ~key_ni;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = flip & sync2_q;

endmodule

// File: rtl/dir_input_queue.sv
// Debounced direction buttons, reversal filter and 2-deep direction queue.
module dir_input_queue
  import dir_input_queue_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input logic              clk_i,
  input logic              rst_ni,
  dir_input_queue_if.slave bus
);

  logic [3:0] key_stable, key_press_raw, key_press;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key_debounce (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .key_ni  (bus.key_n[i]),
      .stable_o(key_stable[i]),
      .press_o (key_press_raw[i])
    );
  end

  // A press is only valid while the registered level is still released.
  assign key_press = key_press_raw & ~key_stable;

  dir_t       dir_out_q, dir_out_d;
  logic       started_q, started_d;
  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, wr_ptr_q;
  dir_t       entry_q [2];

  dir_t req, ref_dir;
  logic pop, push;

  always_comb begin
    req = DIR_NONE;
    if      (key_press[KEY_UP])    req = DIR_UP;
    else if (key_press[KEY_DOWN])  req = DIR_DOWN;
    else if (key_press[KEY_LEFT])  req = DIR_LEFT;
    else if (key_press[KEY_RIGHT]) req = DIR_RIGHT;
  end

  assign pop = bus.tick && !bus.lock && (count_q != 2'd0);

  // The tail entry is also the post-pop reference: when the only entry is
  // popped it becomes dir_out, and the tail still holds that value.
  assign ref_dir = (count_q != 2'd0) ? entry_q[wr_ptr_q - 1'b1] : dir_out_q;

  assign push = (req != DIR_NONE) && (req != ref_dir) && (req != opposite(ref_dir)) &&
                !((count_q == 2'd2) && !pop);

  always_comb begin
    dir_out_d = dir_out_q;
    started_d = started_q;
    if (pop) begin
      dir_out_d = entry_q[rd_ptr_q];
      started_d = 1'b1;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_out_q  <= DIR_NONE;
      started_q  <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      entry_q[0] <= DIR_NONE;
      entry_q[1] <= DIR_NONE;
    end else begin
      dir_out_q <= dir_out_d;
      started_q <= started_d;
      count_q   <= count_d;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push) begin
        entry_q[wr_ptr_q] <= req;
        wr_ptr_q          <= ~wr_ptr_q;
      end
    end
  end

  assign bus.dir_out = dir_out_q;
  assign bus.started = started_q;
  assign bus.q_count = count_q;

endmodule

// File: tb/tb_dir_input_queue.sv
// Directed bench: expected output changes go into a scoreboard, a monitor compares them.
module tb_dir_input_queue;

  typedef struct {
    string      name;
    logic [2:0] dir;
    logic       st;
    logic [1:0] cnt;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  exp_t exp_q[$];

  dir_input_queue_if bus ();

  dir_input_queue #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_chg(input string name, input int d, input int s, input int c,
                            input int at);
    exp_t e;
    e.name = name;
    e.dir  = 3'(d);
    e.st   = 1'(s);
    e.cnt  = 2'(c);
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // Monitor: any change on the outputs must match the next scoreboard entry.
  logic [2:0] prev_dir;
  logic       prev_st;
  logic [1:0] prev_cnt;
  always @(negedge clk) begin
    if (mon_en && (bus.dir_out != prev_dir || bus.started != prev_st ||
                   bus.q_count != prev_cnt)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change: got dir=%0d started=%0d q=%0d expected no change (cycle %0d)",
                 bus.dir_out, bus.started, bus.q_count, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".dir_out"}, int'(bus.dir_out), int'(e.dir));
        chk({e.name, ".started"}, int'(bus.started), int'(e.st));
        chk({e.name, ".q_count"}, int'(bus.q_count), int'(e.cnt));
        if (e.at >= 0) chk({e.name, ".cycle"}, cyc, e.at);
      end
      prev_dir = bus.dir_out;
      prev_st  = bus.started;
      prev_cnt = bus.q_count;
    end
  end

  // Hold a key low, then release it; push an expected change if the press is accepted.
  task automatic press_key(input string name, input int idx, input int hold, input bit acc,
                           input int d, input int s, input int c);
    @(posedge clk);
    #1;
    bus.key_n[idx] = 1'b0;
    if (acc) expect_chg(name, d, s, c, cyc + 5);
    repeat (hold) @(posedge clk);
    #1;
    bus.key_n[idx] = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic tick_pulse(input string name, input bit lk, input bit acc, input int d,
                            input int s, input int c);
    @(posedge clk);
    #1;
    bus.tick = 1'b1;
    bus.lock = lk;
    if (acc) expect_chg(name, d, s, c, cyc + 1);
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    bus.lock = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    bus.key_n = 4'hF;
    bus.tick  = 1'b0;
    bus.lock  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.dir_out", int'(bus.dir_out), 0);
    chk("reset.started", int'(bus.started), 0);
    chk("reset.q_count", int'(bus.q_count), 0);
    prev_dir = 3'd0;
    prev_st  = 1'b0;
    prev_cnt = 2'd0;
    mon_en   = 1'b1;

    // 1: up accepted after sync + debounce, then popped by a tick
    press_key("t1_up_push", 3, 10, 1'b1, 0, 0, 1);
    tick_pulse("t1_pop", 1'b0, 1'b1, 1, 1, 0);

    // 2: glitch one cycle short of the debounce window
    press_key("t2_glitch", 3, 2, 1'b0, 0, 0, 0);

    // 3: down is a reversal, left queued, right opposite of queued left
    press_key("t3_down", 2, 8, 1'b0, 0, 0, 0);
    press_key("t3_left", 1, 8, 1'b1, 1, 1, 1);
    press_key("t3_right", 0, 8, 1'b0, 0, 0, 0);

    // 4: down after left fills the queue, right dropped when full
    press_key("t4_down", 2, 8, 1'b1, 1, 1, 2);
    press_key("t4_right_full", 0, 8, 1'b0, 0, 0, 0);
    tick_pulse("t4_pop_left", 1'b0, 1'b1, 3, 1, 1);
    tick_pulse("t4_pop_down", 1'b0, 1'b1, 2, 1, 0);

    // 5: fill with left, up; right press lands on the same edge as a tick
    press_key("t5_left", 1, 8, 1'b1, 2, 1, 1);
    press_key("t5_up", 3, 8, 1'b1, 2, 1, 2);
    @(posedge clk);
    #1;
    bus.key_n[0] = 1'b0;
    expect_chg("t5_pop_push", 3, 1, 2, cyc + 5);
    repeat (4) @(posedge clk);
    #1;
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.key_n[0] = 1'b1;
    repeat (10) @(posedge clk);

    // 6: pop to one entry, locked tick lost, async reset mid-debounce
    tick_pulse("t6_pop_up", 1'b0, 1'b1, 1, 1, 1);
    tick_pulse("t6_locked", 1'b1, 1'b0, 0, 0, 0);
    @(posedge clk);
    #1;
    bus.key_n[2] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    expect_chg("t6_reset", 0, 0, 0, cyc);
    rst_n = 1'b0;
    #1;
    bus.key_n = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
